// File: rtl/riscv_pkg.sv
// Shared constants and types for the hazard unit: mul/div FSM states,
// forwarding select encodings and the opcodes the forwarding path cares about.
package riscv_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_e;

    localparam logic [6:0] OPC_LUI = 7'b0110111;

    localparam logic [1:0] FWD_NONE = 2'd0;
    localparam logic [1:0] FWD_WB   = 2'd1;
    localparam logic [1:0] FWD_MEM  = 2'd2;
    localparam logic [1:0] FWD_LUI  = 2'd3;

    localparam logic [1:0] RES_LOAD = 2'b10;

endpackage

// File: rtl/riscv_hzrdu_fwdsel.sv
// Forwarding select for one E-stage source operand; purely combinational.
// x0 is never forwarded since it is hardwired to zero.
module riscv_hzrdu_fwdsel
    import riscv_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic [ADDR_W-1:0] rs_e,
    input  logic [ADDR_W-1:0] rd_m,
    input  logic [ADDR_W-1:0] rd_w,
    input  logic              regw_m,
    input  logic              regw_w,
    input  logic              lui_m,
    output logic [1:0]        fwd
);

    logic src_nz;

    assign src_nz = (rs_e != '0);

    always_comb begin
        fwd = FWD_NONE;
        if (src_nz && regw_m && (rs_e == rd_m)) begin
            fwd = lui_m ? FWD_LUI : FWD_MEM;
        end else if (src_nz && regw_w && (rs_e == rd_w)) begin
            fwd = FWD_WB;
        end
    end

endmodule

// File: rtl/riscv_hzrdu_scbd.sv
// Pipeline hazard unit: operand forwarding, load-use and mul/div stalls,
// flush control, sticky mul/div timeout and saturating performance counters.
//
//   state | meaning
//   IDLE  | no multi-cycle op outstanding, busy counter held at 0
//   BUSY  | mul/div issued and waiting for valid, busy counter running
module riscv_hzrdu_scbd
    import riscv_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16,
    parameter int MD_TMO = 64
) (
    input  logic              i_riscv_hzrdu_clk,
    input  logic              i_riscv_hzrdu_rst,
    input  logic [ADDR_W-1:0] i_riscv_hzrdu_rs1addr_d,
    input  logic [ADDR_W-1:0] i_riscv_hzrdu_rs2addr_d,
    input  logic [ADDR_W-1:0] i_riscv_hzrdu_rs1addr_e,
    input  logic [ADDR_W-1:0] i_riscv_hzrdu_rs2addr_e,
    input  logic [ADDR_W-1:0] i_riscv_hzrdu_rdaddr_e,
    input  logic [ADDR_W-1:0] i_riscv_hzrdu_rdaddr_m,
    input  logic [ADDR_W-1:0] i_riscv_hzrdu_rdaddr_w,
    input  logic              i_riscv_hzrdu_regw_m,
    input  logic              i_riscv_hzrdu_regw_w,
    input  logic [6:0]        i_riscv_hzrdu_opcode_m,
    input  logic [1:0]        i_riscv_hzrdu_resultsrc_e,
    input  logic              i_riscv_hzrdu_pcsrc,
    input  logic              i_riscv_hzrdu_mul_en,
    input  logic              i_riscv_hzrdu_div_en,
    input  logic              i_riscv_hzrdu_valid,
    output logic [1:0]        o_riscv_hzrdu_fwda,
    output logic [1:0]        o_riscv_hzrdu_fwdb,
    output logic              o_riscv_hzrdu_stallpc,
    output logic              o_riscv_hzrdu_stallfd,
    output logic              o_riscv_hzrdu_stallde,
    output logic              o_riscv_hzrdu_stallem,
    output logic              o_riscv_hzrdu_stallmw,
    output logic              o_riscv_hzrdu_flushfd,
    output logic              o_riscv_hzrdu_flushde,
    output logic              o_riscv_hzrdu_md_tmo,
    output logic [CNT_W-1:0]  o_riscv_hzrdu_cnt_lu,
    output logic [CNT_W-1:0]  o_riscv_hzrdu_cnt_md,
    output logic [CNT_W-1:0]  o_riscv_hzrdu_cnt_fl
);

    localparam int TMO_W = $clog2(MD_TMO + 1);
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(MD_TMO);
    localparam logic [TMO_W-1:0] TMO_SET = TMO_W'(MD_TMO - 1);

    md_state_e        state;
    logic [TMO_W-1:0] busy_cnt;
    logic             lui_m;
    logic             lu;
    logic             md_req;
    logic             md_stall;

    assign lui_m = (i_riscv_hzrdu_opcode_m == OPC_LUI);

    riscv_hzrdu_fwdsel #(.ADDR_W(ADDR_W)) u_fwd_rs1 (
        .rs_e   (i_riscv_hzrdu_rs1addr_e),
        .rd_m   (i_riscv_hzrdu_rdaddr_m),
        .rd_w   (i_riscv_hzrdu_rdaddr_w),
        .regw_m (i_riscv_hzrdu_regw_m),
        .regw_w (i_riscv_hzrdu_regw_w),
        .lui_m  (lui_m),
        .fwd    (o_riscv_hzrdu_fwda)
    );

    riscv_hzrdu_fwdsel #(.ADDR_W(ADDR_W)) u_fwd_rs2 (
        .rs_e   (i_riscv_hzrdu_rs2addr_e),
        .rd_m   (i_riscv_hzrdu_rdaddr_m),
        .rd_w   (i_riscv_hzrdu_rdaddr_w),
        .regw_m (i_riscv_hzrdu_regw_m),
        .regw_w (i_riscv_hzrdu_regw_w),
        .lui_m  (lui_m),
        .fwd    (o_riscv_hzrdu_fwdb)
    );

    assign lu = (i_riscv_hzrdu_resultsrc_e == RES_LOAD) &&
                (i_riscv_hzrdu_rdaddr_e != '0) &&
                ((i_riscv_hzrdu_rs1addr_d == i_riscv_hzrdu_rdaddr_e) ||
                 (i_riscv_hzrdu_rs2addr_d == i_riscv_hzrdu_rdaddr_e));

    // Stall follows the request directly so a multi-cycle op holds E on its issue cycle.
    assign md_req   = i_riscv_hzrdu_mul_en || i_riscv_hzrdu_div_en;
    assign md_stall = md_req && !i_riscv_hzrdu_valid;

    assign o_riscv_hzrdu_stallpc = lu || md_stall;
    assign o_riscv_hzrdu_stallfd = lu || md_stall;
    assign o_riscv_hzrdu_stallde = md_stall;
    assign o_riscv_hzrdu_stallem = md_stall;
    assign o_riscv_hzrdu_stallmw = md_stall;
    assign o_riscv_hzrdu_flushfd = i_riscv_hzrdu_pcsrc;
    assign o_riscv_hzrdu_flushde = (lu || i_riscv_hzrdu_pcsrc) && !md_stall;

    always_ff @(posedge i_riscv_hzrdu_clk or posedge i_riscv_hzrdu_rst) begin
        if (i_riscv_hzrdu_rst) begin
            state                <= IDLE;
            busy_cnt             <= '0;
            o_riscv_hzrdu_md_tmo <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    busy_cnt <= '0;
                    if (md_req && !i_riscv_hzrdu_valid) begin
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (busy_cnt != TMO_MAX) begin
                        busy_cnt <= busy_cnt + TMO_W'(1);
                    end
                    // Timeout only flags; the op keeps stalling until valid or reset.
                    if (busy_cnt == TMO_SET) begin
                        o_riscv_hzrdu_md_tmo <= 1'b1;
                    end
                    if (i_riscv_hzrdu_valid) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    busy_cnt <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_riscv_hzrdu_clk or posedge i_riscv_hzrdu_rst) begin
        if (i_riscv_hzrdu_rst) begin
            o_riscv_hzrdu_cnt_lu <= '0;
            o_riscv_hzrdu_cnt_md <= '0;
            o_riscv_hzrdu_cnt_fl <= '0;
        end else begin
            if (lu && !md_stall && (o_riscv_hzrdu_cnt_lu != '1)) begin
                o_riscv_hzrdu_cnt_lu <= o_riscv_hzrdu_cnt_lu + CNT_W'(1);
            end
            if (md_stall && (o_riscv_hzrdu_cnt_md != '1)) begin
                o_riscv_hzrdu_cnt_md <= o_riscv_hzrdu_cnt_md + CNT_W'(1);
            end
            if (i_riscv_hzrdu_pcsrc && (o_riscv_hzrdu_cnt_fl != '1)) begin
                o_riscv_hzrdu_cnt_fl <= o_riscv_hzrdu_cnt_fl + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_riscv_hzrdu_scbd.sv
// Bench for riscv_hzrdu_scbd: two instances (default sizing, and small counters
// with a short timeout) driven in parallel and checked against a behavioural model.
module tb_riscv_hzrdu_scbd;

    localparam int TMO_L [2] = '{64, 4};
    localparam int CMAX  [2] = '{65535, 7};
    localparam logic [6:0] LUI = 7'b0110111;
    localparam logic [6:0] OPR = 7'b0110011;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] rs1_d = '0, rs2_d = '0, rs1_e = '0, rs2_e = '0;
    logic [4:0] rd_e = '0, rd_m = '0, rd_w = '0;
    logic       regw_m = 1'b0, regw_w = 1'b0, pcsrc = 1'b0;
    logic [6:0] opc_m = '0;
    logic [1:0] rsrc_e = '0;
    logic       mul_en = 1'b0, div_en = 1'b0, valid = 1'b0;

    logic [1:0]  a_fwda, a_fwdb, b_fwda, b_fwdb;
    logic        a_spc, a_sfd, a_sde, a_sem, a_smw, a_ffd, a_fde, a_tmo;
    logic        b_spc, b_sfd, b_sde, b_sem, b_smw, b_ffd, b_fde, b_tmo;
    logic [15:0] a_clu, a_cmd, a_cfl;
    logic [2:0]  b_clu, b_cmd, b_cfl;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;
    int stall_cyc = 0;
    int flfd_cyc = 0;

    // Model state per instance.
    bit m_busy [2] = '{1'b0, 1'b0};
    int m_bcnt [2] = '{0, 0};
    bit m_tmo  [2] = '{1'b0, 1'b0};
    int m_lu   [2] = '{0, 0};
    int m_md   [2] = '{0, 0};
    int m_fl   [2] = '{0, 0};

    always #5 clk = ~clk;

    riscv_hzrdu_scbd dut_a (
        .i_riscv_hzrdu_clk(clk), .i_riscv_hzrdu_rst(rst),
        .i_riscv_hzrdu_rs1addr_d(rs1_d), .i_riscv_hzrdu_rs2addr_d(rs2_d),
        .i_riscv_hzrdu_rs1addr_e(rs1_e), .i_riscv_hzrdu_rs2addr_e(rs2_e),
        .i_riscv_hzrdu_rdaddr_e(rd_e), .i_riscv_hzrdu_rdaddr_m(rd_m),
        .i_riscv_hzrdu_rdaddr_w(rd_w), .i_riscv_hzrdu_regw_m(regw_m),
        .i_riscv_hzrdu_regw_w(regw_w), .i_riscv_hzrdu_opcode_m(opc_m),
        .i_riscv_hzrdu_resultsrc_e(rsrc_e), .i_riscv_hzrdu_pcsrc(pcsrc),
        .i_riscv_hzrdu_mul_en(mul_en), .i_riscv_hzrdu_div_en(div_en),
        .i_riscv_hzrdu_valid(valid),
        .o_riscv_hzrdu_fwda(a_fwda), .o_riscv_hzrdu_fwdb(a_fwdb),
        .o_riscv_hzrdu_stallpc(a_spc), .o_riscv_hzrdu_stallfd(a_sfd),
        .o_riscv_hzrdu_stallde(a_sde), .o_riscv_hzrdu_stallem(a_sem),
        .o_riscv_hzrdu_stallmw(a_smw), .o_riscv_hzrdu_flushfd(a_ffd),
        .o_riscv_hzrdu_flushde(a_fde), .o_riscv_hzrdu_md_tmo(a_tmo),
        .o_riscv_hzrdu_cnt_lu(a_clu), .o_riscv_hzrdu_cnt_md(a_cmd),
        .o_riscv_hzrdu_cnt_fl(a_cfl)
    );

    riscv_hzrdu_scbd #(.ADDR_W(5), .CNT_W(3), .MD_TMO(4)) dut_b (
        .i_riscv_hzrdu_clk(clk), .i_riscv_hzrdu_rst(rst),
        .i_riscv_hzrdu_rs1addr_d(rs1_d), .i_riscv_hzrdu_rs2addr_d(rs2_d),
        .i_riscv_hzrdu_rs1addr_e(rs1_e), .i_riscv_hzrdu_rs2addr_e(rs2_e),
        .i_riscv_hzrdu_rdaddr_e(rd_e), .i_riscv_hzrdu_rdaddr_m(rd_m),
        .i_riscv_hzrdu_rdaddr_w(rd_w), .i_riscv_hzrdu_regw_m(regw_m),
        .i_riscv_hzrdu_regw_w(regw_w), .i_riscv_hzrdu_opcode_m(opc_m),
        .i_riscv_hzrdu_resultsrc_e(rsrc_e), .i_riscv_hzrdu_pcsrc(pcsrc),
        .i_riscv_hzrdu_mul_en(mul_en), .i_riscv_hzrdu_div_en(div_en),
        .i_riscv_hzrdu_valid(valid),
        .o_riscv_hzrdu_fwda(b_fwda), .o_riscv_hzrdu_fwdb(b_fwdb),
        .o_riscv_hzrdu_stallpc(b_spc), .o_riscv_hzrdu_stallfd(b_sfd),
        .o_riscv_hzrdu_stallde(b_sde), .o_riscv_hzrdu_stallem(b_sem),
        .o_riscv_hzrdu_stallmw(b_smw), .o_riscv_hzrdu_flushfd(b_ffd),
        .o_riscv_hzrdu_flushde(b_fde), .o_riscv_hzrdu_md_tmo(b_tmo),
        .o_riscv_hzrdu_cnt_lu(b_clu), .o_riscv_hzrdu_cnt_md(b_cmd),
        .o_riscv_hzrdu_cnt_fl(b_cfl)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_fwd(input logic [4:0] rs);
        if (rs != 0 && regw_m && rs == rd_m) return (opc_m == LUI) ? 3 : 2;
        if (rs != 0 && regw_w && rs == rd_w) return 1;
        return 0;
    endfunction

    function automatic bit exp_lu();
        return rsrc_e == 2'b10 && rd_e != 0 && (rs1_d == rd_e || rs2_d == rd_e);
    endfunction

    function automatic bit exp_mds();
        return (mul_en || div_en) && !valid;
    endfunction

    function automatic int sat(input int v, input int mx);
        return (v >= mx) ? mx : v + 1;
    endfunction

    // Model: a BUSY episode begins on a stalled request from idle and lasts until valid.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                m_busy[i] = 1'b0; m_bcnt[i] = 0; m_tmo[i] = 1'b0;
                m_lu[i] = 0; m_md[i] = 0; m_fl[i] = 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (exp_lu() && !exp_mds()) m_lu[i] = sat(m_lu[i], CMAX[i]);
                if (exp_mds())              m_md[i] = sat(m_md[i], CMAX[i]);
                if (pcsrc)                  m_fl[i] = sat(m_fl[i], CMAX[i]);
                if (m_busy[i]) begin
                    if (m_bcnt[i] < TMO_L[i]) m_bcnt[i] = m_bcnt[i] + 1;
                    if (m_bcnt[i] >= TMO_L[i]) m_tmo[i] = 1'b1;
                    if (valid) m_busy[i] = 1'b0;
                end else begin
                    m_bcnt[i] = 0;
                    if (exp_mds()) m_busy[i] = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            int ef;
            bit el, em, ff, fd;
            el = exp_lu(); em = exp_mds();
            ff = pcsrc; fd = (el || pcsrc) && !em;
            chk("a.fwda", a_fwda, exp_fwd(rs1_e)); chk("b.fwda", b_fwda, exp_fwd(rs1_e));
            chk("a.fwdb", a_fwdb, exp_fwd(rs2_e)); chk("b.fwdb", b_fwdb, exp_fwd(rs2_e));
            ef = int'(el || em);
            chk("a.stallpc", a_spc, ef); chk("a.stallfd", a_sfd, ef);
            chk("b.stallpc", b_spc, ef); chk("b.stallfd", b_sfd, ef);
            chk("a.stallde", a_sde, em); chk("a.stallem", a_sem, em); chk("a.stallmw", a_smw, em);
            chk("b.stallde", b_sde, em); chk("b.stallem", b_sem, em); chk("b.stallmw", b_smw, em);
            chk("a.flushfd", a_ffd, ff); chk("b.flushfd", b_ffd, ff);
            chk("a.flushde", a_fde, fd); chk("b.flushde", b_fde, fd);
            chk("a.md_tmo", a_tmo, m_tmo[0]); chk("b.md_tmo", b_tmo, m_tmo[1]);
            chk("a.cnt_lu", a_clu, m_lu[0]); chk("b.cnt_lu", b_clu, m_lu[1]);
            chk("a.cnt_md", a_cmd, m_md[0]); chk("b.cnt_md", b_cmd, m_md[1]);
            chk("a.cnt_fl", a_cfl, m_fl[0]); chk("b.cnt_fl", b_cfl, m_fl[1]);
            if (a_sde) stall_cyc++;
            if (a_ffd) flfd_cyc++;
        end
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(1);
    endtask

    task automatic idle_inputs();
        rs1_d = '0; rs2_d = '0; rs1_e = '0; rs2_e = '0;
        rd_e = '0; rd_m = '0; rd_w = '0; regw_m = 1'b0; regw_w = 1'b0;
        opc_m = '0; rsrc_e = '0; pcsrc = 1'b0;
        mul_en = 1'b0; div_en = 1'b0; valid = 1'b0;
    endtask

    typedef struct { logic [4:0] r1, r2, rm, rw; logic wm, ww; logic [6:0] op; } fwd_vec_t;
    fwd_vec_t fv [6];

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        fv[0] = '{5'd3, 5'd4, 5'd3, 5'd4, 1'b1, 1'b1, OPR};
        fv[1] = '{5'd3, 5'd4, 5'd4, 5'd3, 1'b0, 1'b1, LUI};
        fv[2] = '{5'd8, 5'd8, 5'd8, 5'd8, 1'b1, 1'b1, LUI};
        fv[3] = '{5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, LUI};
        fv[4] = '{5'd9, 5'd1, 5'd2, 5'd9, 1'b1, 1'b0, OPR};
        fv[5] = '{5'd31, 5'd30, 5'd31, 5'd30, 1'b1, 1'b1, OPR};

        step(3);
        rst = 1'b0;
        step(1);
        chk_en = 1'b1;
        chk("rst.a.cnt_md", a_cmd, 0);
        chk("rst.b.md_tmo", b_tmo, 0);

        // Forwarding literals.
        rs1_e = 5'd5; rd_m = 5'd5; regw_m = 1'b1; opc_m = LUI; #1;
        chk("lit.fwda_lui", a_fwda, 3);
        opc_m = OPR; #1;
        chk("lit.fwda_mem", a_fwda, 2);
        rs1_e = 5'd0; rd_m = 5'd0; rd_e = 5'd0; #1;
        chk("lit.fwda_x0", a_fwda, 0);
        rs2_e = 5'd9; rd_w = 5'd9; regw_w = 1'b1; #1;
        chk("lit.fwdb_wb", b_fwdb, 1);
        step(1);
        foreach (fv[k]) begin
            rs1_e = fv[k].r1; rs2_e = fv[k].r2; rd_m = fv[k].rm; rd_w = fv[k].rw;
            regw_m = fv[k].wm; regw_w = fv[k].ww; opc_m = fv[k].op;
            step(1);
        end
        idle_inputs();

        // Load-use for a single cycle.
        rsrc_e = 2'b10; rd_e = 5'd7; rs2_d = 5'd7; #1;
        chk("lit.lu_stallpc", a_spc, 1);
        chk("lit.lu_flushde", a_fde, 1);
        step(1);
        idle_inputs();
        step(1);
        chk("lit.cnt_lu", a_clu, 1);

        // Divide held off by valid for 10 cycles.
        stall_cyc = 0;
        div_en = 1'b1;
        step(10);
        valid = 1'b1;
        step(1);
        idle_inputs();
        step(2);
        chk("lit.md_stall_cycles", stall_cyc, 10);
        chk("lit.a_cnt_md", a_cmd, 10);
        chk("lit.b_cnt_md_sat", b_cmd, 7);
        chk("lit.a_tmo_clear", a_tmo, 0);

        // Timeout on the short instance.
        pulse_rst();
        mul_en = 1'b1;
        step(4);
        chk("lit.tmo_before", b_tmo, 0);
        step(1);
        chk("lit.tmo_set", b_tmo, 1);
        chk("lit.tmo_stall_held", b_sde, 1);
        valid = 1'b1;
        step(1);
        idle_inputs();
        step(2);
        chk("lit.tmo_sticky", b_tmo, 1);

        // Reset during BUSY.
        pulse_rst();
        mul_en = 1'b1;
        step(3);
        #2;
        rst = 1'b1;
        mul_en = 1'b0;
        step(1);
        rst = 1'b0;
        step(2);
        chk("lit.rst_busy_stall", a_sde, 0);
        chk("lit.rst_busy_cnt_md", a_cmd, 0);
        chk("lit.rst_busy_tmo", b_tmo, 0);

        // Flush counter saturation.
        flfd_cyc = 0;
        pcsrc = 1'b1;
        step(10);
        pcsrc = 1'b0;
        step(1);
        chk("lit.flushfd_cycles", flfd_cyc, 10);
        chk("lit.b_cnt_fl_sat", b_cfl, 7);
        chk("lit.a_cnt_fl", a_cfl, 10);

        // Load-use overlapping a mul/div stall: only the mul/div counter moves.
        pulse_rst();
        rsrc_e = 2'b10; rd_e = 5'd7; rs1_d = 5'd7; div_en = 1'b1; #1;
        chk("lit.both_flushde", a_fde, 0);
        step(3);
        valid = 1'b1;
        step(1);
        idle_inputs();
        step(2);
        chk("lit.both_cnt_lu", a_clu, 1);
        chk("lit.both_cnt_md", a_cmd, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/riscv_hzrdu_scbd.md
RISCV_HZRDU_SCBD -- requirements
Module: riscv_hzrdu_scbd

Interface
REQ-001 SHALL have parameter ADDR_W, default 5: register address width.
REQ-002 SHALL have parameter CNT_W, default 16: width of each performance counter.
REQ-003 SHALL have parameter MD_TMO, default 64: maximum mul/div busy cycles before a timeout.
REQ-004 SHALL have ports i_riscv_hzrdu_clk, in, 1, the only clock, and i_riscv_hzrdu_rst, in, 1, asynchronous active-high reset.
REQ-005 SHALL have ports i_riscv_hzrdu_rs1addr_d/rs2addr_d/rs1addr_e/rs2addr_e/rdaddr_e/rdaddr_m/rdaddr_w, in, ADDR_W each: pipeline register addresses.
REQ-006 SHALL have ports i_riscv_hzrdu_regw_m and regw_w (in, 1), i_riscv_hzrdu_opcode_m (in, 7), i_riscv_hzrdu_resultsrc_e (in, 2) and i_riscv_hzrdu_pcsrc (in, 1).
REQ-007 SHALL have ports i_riscv_hzrdu_mul_en, div_en and valid, in, 1 each: multi-cycle unit issue in E and its completion.
REQ-008 SHALL have ports o_riscv_hzrdu_fwda and fwdb, out, 2 each: operand forwarding selects.
REQ-009 SHALL have ports o_riscv_hzrdu_stallpc/stallfd/stallde/stallem/stallmw and flushfd/flushde, out, 1 each.
REQ-010 SHALL have port o_riscv_hzrdu_md_tmo, out, 1: sticky mul/div timeout flag.
REQ-011 SHALL have ports o_riscv_hzrdu_cnt_lu, cnt_md and cnt_fl, out, CNT_W each: load-use stall, mul/div stall and flush cycle counters.

Function
REQ-012 SHALL compute fwda, and identically fwdb on rs2, combinationally by priority:
 - 3: rs1_e==rd_m, regw_m, rd_m!=0 and opcode_m==0110111 (LUI).
 - 2: rs1_e==rd_m, regw_m, rd_m!=0.
 - 1: rs1_e==rd_w, regw_w, rd_w!=0.
 - 0: otherwise.
REQ-013 SHALL never forward for a source address of 0, whatever rd_e is.
REQ-014 SHALL define lu = resultsrc_e==2'b10 and rd_e!=0 and (rs1_d==rd_e or rs2_d==rd_e).
REQ-015 SHALL run a mul/div FSM with states IDLE and BUSY; md_req = mul_en or div_en.
 - IDLE to BUSY when md_req and !valid.
 - IDLE stays IDLE when md_req and valid in the same cycle (single-cycle result).
 - BUSY to IDLE when valid.
 - BUSY stays BUSY otherwise.
REQ-016 SHALL assert md_stall combinationally = md_req and !valid, in both states, with no cycle of lag.
REQ-017 SHALL drive stallpc = stallfd = lu or md_stall.
REQ-018 SHALL drive stallde = stallem = stallmw = md_stall.
REQ-019 SHALL drive flushfd = pcsrc and flushde = (lu or pcsrc) and !md_stall.
REQ-020 SHALL keep a busy counter that clears in IDLE and increments each BUSY cycle.
REQ-021 SHALL set md_tmo when the busy counter reaches MD_TMO.
REQ-022 SHALL hold md_tmo until reset; the stall stays asserted and md_tmo does not force completion.
REQ-023 SHALL increment cnt_lu each cycle lu and !md_stall.
REQ-024 SHALL increment cnt_md each cycle md_stall.
REQ-025 SHALL increment cnt_fl each cycle pcsrc.
REQ-026 SHALL saturate every counter at all-ones, with no wrap.
REQ-027 SHALL let md_stall dominate when lu and md_stall are both true: only cnt_md counts and flushde is 0.

Reset
REQ-028 SHALL, on rst high, asynchronously force the FSM to IDLE and clear the busy counter, md_tmo and all three perf counters to 0.
REQ-029 SHALL abandon a BUSY operation when reset asserts mid-operation, with no residual stall after release.
REQ-030 SHALL keep the combinational outputs purely input-driven during reset.

Structure
REQ-031 SHALL place the FSM state enum (IDLE, BUSY) and opcode constant OPC_LUI=7'b0110111 in shared package riscv_pkg.
REQ-032 SHALL implement the forwarding compare as one sub-module, riscv_hzrdu_fwdsel, instantiated twice (rs1, rs2).

Verification
REQ-033 SHALL cover forwarding: rs1_e=5, rd_m=5, regw_m=1, opcode_m=LUI -> fwda=3; opcode_m=0110011 -> fwda=2; rs1_e=0, rd_m=0 -> fwda=0.
REQ-034 SHALL cover load-use: resultsrc_e=2, rd_e=7, rs2_d=7 -> stallpc=stallfd=flushde=1 for one cycle, cnt_lu=1.
REQ-035 SHALL cover a mul/div stall: div_en=1, valid low for 10 cycles, then high -> stallde/em/mw high exactly 10 cycles, FSM back to IDLE, cnt_md=10.
REQ-036 SHALL cover timeout: MD_TMO=4, mul_en held with valid=0 -> md_tmo set on the cycle the busy count reaches 4 and stays set after valid.
REQ-037 SHALL cover counter saturation: CNT_W=3, pcsrc high for 10 cycles -> cnt_fl=7, and flushfd high for all 10 cycles.
REQ-038 SHALL cover reset mid-BUSY: rst pulse on BUSY cycle 3 with mul_en then low -> all stalls 0 and counters 0 after reset.
